qft_phase_gen: RTL

- Upstream feeder for the pipelined QFT cosine/sine approximation stages.
- For an N = 2^N_LOG2 point transform, it walks every (j, k) pair in row-major order and emits the twiddle phase theta = ∓2π·((j·k) mod N)/N.
- Phase is signed fixed point per fixed_point_params.vh (`TOTAL_WIDTH`, `FRAC_WIDTH`), inside the approximator's valid input range [-2π, 2π].
- The index product is built incrementally, so no j·k multiplier is needed; samples are delivered over a valid/ready handshake with full backpressure.

---
 rtl/qft_phase_gen_if.sv | 30 +++
 rtl/qft_phase_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/qft_phase_gen_if.sv
// Output stream of the QFT twiddle-phase generator: one phase sample
// tagged with its (j, k) index pair, moved by a valid/ready handshake.
interface qft_phase_gen_if #(
    parameter int N_LOG2      = 2,
    parameter int TOTAL_WIDTH = 16
);
    logic                           out_valid;
    logic                           out_ready;
    logic signed [TOTAL_WIDTH-1:0]  phase_out;
    logic        [N_LOG2-1:0]       j_out;
    logic        [N_LOG2-1:0]       k_out;

    // Producer side (the generator)
    modport master (
        output out_valid,
        output phase_out,
        output j_out,
        output k_out,
        input  out_ready
    );

    // Consumer side (the cosine/sine approximation stage)
    modport slave (
        input  out_valid,
        input  phase_out,
        input  j_out,
        input  k_out,
        output out_ready
    );
endinterface

// File: rtl/qft_phase_gen.sv
// QFT twiddle-phase generator. Walks every (j, k) pair of an N = 2^N_LOG2
// point transform in row-major order and emits theta = -/+ idx * (2*pi/N),
// where idx = (j*k) mod N is accumulated incrementally (no multiplier on j*k).
// TOTAL_WIDTH is the signed fixed-point width of the phase; PHASE_STEP is
// round(2*pi * 2^FRAC_WIDTH / N) in that same format.
module qft_phase_gen #(
    parameter int N_LOG2      = 2,
    parameter int TOTAL_WIDTH = 16,
    parameter int PHASE_STEP  = 25,
    parameter bit INVERSE     = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    qft_phase_gen_if.master out_if,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [N_LOG2-1:0]      LAST = {N_LOG2{1'b1}};
    localparam logic [TOTAL_WIDTH-1:0] STEP = TOTAL_WIDTH'(PHASE_STEP);

    state_t state_q, state_d;

    // Generator: next (j, k) to emit and its running (j*k) mod N
    logic [N_LOG2-1:0] j_q, j_d;
    logic [N_LOG2-1:0] k_q, k_d;
    logic [N_LOG2-1:0] idx_q, idx_d;
    logic              gen_exh_q, gen_exh_d;

    // Output register
    logic                          valid_q, valid_d;
    logic signed [TOTAL_WIDTH-1:0] phase_q, phase_d;
    logic        [N_LOG2-1:0]      jo_q, jo_d;
    logic        [N_LOG2-1:0]      ko_q, ko_d;

    logic                   transfer;
    logic                   load;
    logic                   gen_last;
    logic [TOTAL_WIDTH-1:0] mag;
    logic [TOTAL_WIDTH-1:0] phase_gen;

    assign transfer = valid_q && out_if.out_ready;
    assign gen_last = (j_q == LAST) && (k_q == LAST);
    // Refill the output slot whenever it is empty or being drained this cycle
    assign load     = (state_q == S_RUN) && (!valid_q || out_if.out_ready) && !gen_exh_q;

    // Phase magnitude and sign; idx=0 yields exactly 0 for either sign
    always_comb begin
        mag       = {{(TOTAL_WIDTH-N_LOG2){1'b0}}, idx_q} * STEP;
        phase_gen = INVERSE ? mag : (~mag + 1'b1);
    end

    // Sequencer and generator next-state logic with decoded status outputs
    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        k_d       = k_q;
        idx_d     = idx_q;
        gen_exh_d = gen_exh_q;
        valid_d   = valid_q;
        phase_d   = phase_q;
        jo_d      = jo_q;
        ko_d      = ko_q;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    j_d       = '0;
                    k_d       = '0;
                    idx_d     = '0;
                    gen_exh_d = 1'b0;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                // Last sample leaves the output register on this edge
                if (transfer && gen_exh_q && (jo_q == LAST) && (ko_q == LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (transfer) begin
            valid_d = 1'b0;
        end

        if (load) begin
            valid_d = 1'b1;
            phase_d = signed'(phase_gen);
            jo_d    = j_q;
            ko_d    = k_q;
            // Advance the generator; N_LOG2-bit wrap is the mod N
            if (k_q != LAST) begin
                k_d   = k_q + 1'b1;
                idx_d = idx_q + j_q;
            end else begin
                k_d   = '0;
                j_d   = j_q + 1'b1;
                idx_d = '0;
            end
            if (gen_last) begin
                gen_exh_d = 1'b1;
            end
        end
    end

    // State, generator and output registers; reset aborts any sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            j_q       <= '0;
            k_q       <= '0;
            idx_q     <= '0;
            gen_exh_q <= 1'b0;
            valid_q   <= 1'b0;
            phase_q   <= '0;
            jo_q      <= '0;
            ko_q      <= '0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            k_q       <= k_d;
            idx_q     <= idx_d;
            gen_exh_q <= gen_exh_d;
            valid_q   <= valid_d;
            phase_q   <= phase_d;
            jo_q      <= jo_d;
            ko_q      <= ko_d;
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.phase_out = phase_q;
    assign out_if.j_out     = jo_q;
    assign out_if.k_out     = ko_q;

endmodule
